enc_tx_sched: RTL

//   Transmit scheduler in front of the USB packet encoder. Two requesters share the single encoder:

---
 rtl/enc_tx_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/enc_tx_sched.sv
// enc_tx_sched -- transmit scheduler in front of the USB packet encoder.
//
// Two requesters share one encoder: port 0 (protocol FSM: tokens and
// handshakes) and port 1 (data packets). One packet is granted and latched.
// enc_pkt_avail is held until the encoder reports enc_pkt_sent. An
// inter-packet gap is then enforced so the encoder counters can clear, and
// the owner gets a one-cycle done pulse. A watchdog aborts a packet that the
// encoder never completes.
//
// Ports
//   clk            clock, all state on posedge
//   rst            asynchronous active-high reset
//   p0_pkt         port 0 packet, stable while p0_valid and not yet accepted
//   p0_valid       port 0 request
//   p0_ready       port 0 accept (combinational, IDLE only)
//   p0_done        one-cycle pulse: port 0 packet finished (sent or aborted)
//   p1_*           same as port 0, for port 1
//   enc_pkt        packet to encoder (holds last value until next grant)
//   enc_pkt_avail  encoder enable, high for the whole SEND state
//   enc_pkt_sent   encoder completion, only looked at in SEND
//   owner          port being served (meaningful while busy)
//   busy           scheduler not IDLE
//   tx_err         one-cycle pulse with done when the watchdog aborted
module enc_tx_sched #(
  parameter int PKT_W      = 99,
  parameter int IPG        = 2,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] p0_pkt,
  input  logic             p0_valid,
  output logic             p0_ready,
  output logic             p0_done,
  input  logic [PKT_W-1:0] p1_pkt,
  input  logic             p1_valid,
  output logic             p1_ready,
  output logic             p1_done,
  output logic [PKT_W-1:0] enc_pkt,
  output logic             enc_pkt_avail,
  input  logic             enc_pkt_sent,
  output logic             owner,
  output logic             busy,
  output logic             tx_err
);

  localparam int WDOG_W = $clog2(TIMEOUT);
  localparam int GAP_W  = $clog2(IPG + 1);
  localparam int CONS_W = $clog2(MAX_CONSEC + 1);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IPG - 1);
  localparam logic [CONS_W-1:0] CONS_MAX  = CONS_W'(MAX_CONSEC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [WDOG_W-1:0]   wdog_q;
  logic [GAP_W-1:0]    gap_q;
  logic [CONS_W-1:0]   consec_q;

  logic                grant0;
  logic                grant1;
  logic                leave_send;
  logic                abort;

  // Next-state, arbitration and SEND exit decode
  always_comb begin
    state_d    = state_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    leave_send = 1'b0;
    abort      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Port 0 wins unless port 1 has been starved for MAX_CONSEC grants.
        grant0 = p0_valid && !(p1_valid && (consec_q == CONS_MAX));
        grant1 = !grant0 && p1_valid;
        if (grant0 || grant1) state_d = S_SEND;
      end
      S_SEND: begin
        // A completion in the watchdog's last cycle still counts as sent.
        if (enc_pkt_sent) begin
          leave_send = 1'b1;
          state_d    = S_GAP;
        end else if (wdog_q == WDOG_LAST) begin
          leave_send = 1'b1;
          abort      = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Readies are forced low while reset is asserted so every output reads 0.
  assign p0_ready      = grant0 && !rst;
  assign p1_ready      = grant1 && !rst;
  assign enc_pkt_avail = (state_q == S_SEND);
  assign busy          = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Grant latch, counters and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_pkt  <= '0;
      owner    <= 1'b0;
      wdog_q   <= '0;
      gap_q    <= '0;
      consec_q <= '0;
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      // done/tx_err land in the first GAP cycle, when avail is already low.
      p0_done <= leave_send && !owner;
      p1_done <= leave_send && owner;
      tx_err  <= abort;

      if (grant0 || grant1) begin
        enc_pkt <= grant1 ? p1_pkt : p0_pkt;
        owner   <= grant1;
        wdog_q  <= '0;
      end else if ((state_q == S_SEND) && !leave_send) begin
        wdog_q <= wdog_q + 1'b1;
      end

      if (leave_send) begin
        gap_q <= '0;
      end else if ((state_q == S_GAP) && (state_d == S_GAP)) begin
        gap_q <= gap_q + 1'b1;
      end

      // Count port-0 grants taken while port 1 was waiting.
      if (grant1) begin
        consec_q <= '0;
      end else if (grant0) begin
        if (!p1_valid)                 consec_q <= '0;
        else if (consec_q != CONS_MAX) consec_q <= consec_q + 1'b1;
      end
    end
  end

endmodule
